wb_writer: RTL and testbench

- Write-back writer for the pipelined core. It is the sole driver of the register file write port (reg_write / write_reg / write_data).
- Merges two result sources:
  - the MEM/WB pipeline result (ALU or load);
  - a long-latency multiply/divide result, delivered over a valid/ready handshake and held in a small FIFO.
- The register file does not protect $0, so this block suppresses every write to register 0.
- Also exports forwarding data and a pending-destination mask to the hazard unit.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/wb_md_fifo.sv | 78 +++++++
 rtl/wb_writer.sv | 151 +++++++++++++++
 tb/tb_wb_writer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core-wide constants and types used by the write-back stage.
package cpu_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;
   localparam int NUM_REGS   = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [XLEN-1:0]       word_t;

   localparam reg_addr_t REG_ZERO = '0;

   // One queued mul/div result: destination register plus data.
   typedef struct packed {
      reg_addr_t rd;
      word_t     data;
   } wb_entry_t;

   // Which source loads the register-file write port this cycle.
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_FIFO = 2'd1,
      SRC_PIPE = 2'd2
   } wb_src_e;

   function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t r);
      return NUM_REGS'(1) << r;
   endfunction

endpackage

// File: rtl/wb_md_fifo.sv
// Small synchronous FIFO for mul/div results; every entry's destination is
// visible so the writer can build its pending-destination mask.
module wb_md_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             push,
   input  wb_entry_t                        push_entry,
   input  logic                             pop,
   output wb_entry_t                        head,
   output logic                             full,
   output logic                             empty,
   output logic [DEPTH-1:0]                 entry_valid,
   output logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_reg
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic [DEPTH-1:0] valid_reg;
   wb_entry_t        mem_reg [DEPTH];

   logic do_push;
   logic do_pop;

   assign full    = (count_reg == CW'(DEPTH));
   assign empty   = (count_reg == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Push and pop never touch the same slot: that would need the FIFO to be
   // both empty (nothing to pop) and full (push refused) at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         valid_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg            <= wr_ptr_reg + 1'b1;
            valid_reg[wr_ptr_reg] <= 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg            <= rd_ptr_reg + 1'b1;
            valid_reg[rd_ptr_reg] <= 1'b0;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Payload storage needs no reset; valid_reg qualifies every slot.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_reg[wr_ptr_reg] <= push_entry;
      end
   end

   assign head        = mem_reg[rd_ptr_reg];
   assign entry_valid = valid_reg;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_reg
         assign entry_reg[gi] = mem_reg[gi].rd;
      end
   endgenerate

endmodule

// File: rtl/wb_writer.sv
// Write-back writer: merges MEM/WB results with queued mul/div results onto
// the single register-file write port and reports pending destinations.
module wb_writer
   import cpu_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_valid,
   input  logic                  mem_reg_write,
   input  logic                  mem_mem_to_reg,
   input  logic [REG_ADDR_W-1:0] mem_write_reg,
   input  logic [XLEN-1:0]       mem_alu_result,
   input  logic [XLEN-1:0]       mem_read_data,
   output logic                  wb_stall,
   input  logic                  md_valid,
   output logic                  md_ready,
   input  logic [REG_ADDR_W-1:0] md_write_reg,
   input  logic [XLEN-1:0]       md_result,
   output logic                  reg_write,
   output logic [REG_ADDR_W-1:0] write_reg,
   output logic [XLEN-1:0]       write_data,
   output logic [NUM_REGS-1:0]   pending_mask,
   output logic                  waw_err
);

   localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   logic                             pw;
   word_t                            pipe_data;
   logic                             push;
   logic                             pop;
   wb_entry_t                        push_entry;
   wb_entry_t                        head;
   logic                             fifo_full;
   logic                             fifo_empty;
   logic [DEPTH-1:0]                 entry_valid;
   logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_reg;
   logic [NUM_REGS-1:0]              entry_mask [DEPTH];
   wb_src_e                          src;

   logic [SW-1:0]         starve_cnt_reg, starve_cnt_next;
   logic                  reg_write_reg, reg_write_next;
   reg_addr_t             write_reg_reg, write_reg_next;
   word_t                 write_data_reg, write_data_next;
   logic                  waw_err_reg, waw_err_next;

   assign pw        = mem_valid & mem_reg_write & (mem_write_reg != REG_ZERO);
   assign pipe_data = mem_mem_to_reg ? mem_read_data : mem_alu_result;

   // Results aimed at $0 complete the handshake but are never queued.
   assign md_ready   = ~fifo_full;
   assign push       = md_valid & md_ready & (md_write_reg != REG_ZERO);
   assign push_entry = '{rd: md_write_reg, data: md_result};

   wb_md_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (push),
      .push_entry  (push_entry),
      .pop         (pop),
      .head        (head),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .entry_valid (entry_valid),
      .entry_reg   (entry_reg)
   );

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pending
         assign entry_mask[gi] = entry_valid[gi] ? reg_onehot(entry_reg[gi]) : '0;
      end
   endgenerate

   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         pending_mask = pending_mask | entry_mask[i];
      end
   end

   assign wb_stall = ~fifo_empty & (starve_cnt_reg >= LIMIT);

   always_comb begin
      src             = SRC_NONE;
      reg_write_next  = 1'b0;
      write_reg_next  = write_reg_reg;
      write_data_next = write_data_reg;
      starve_cnt_next = starve_cnt_reg;

      if (wb_stall) begin
         src = SRC_FIFO;
      end else if (pw) begin
         src = SRC_PIPE;
      end else if (!fifo_empty) begin
         src = SRC_FIFO;
      end

      case (src)
         SRC_FIFO: begin
            reg_write_next  = 1'b1;
            write_reg_next  = head.rd;
            write_data_next = head.data;
         end
         SRC_PIPE: begin
            reg_write_next  = 1'b1;
            write_reg_next  = mem_write_reg;
            write_data_next = pipe_data;
         end
         default: ;
      endcase

      pop = (src == SRC_FIFO);

      if (fifo_empty || pop) begin
         starve_cnt_next = '0;
      end else if (starve_cnt_reg != LIMIT) begin
         starve_cnt_next = starve_cnt_reg + 1'b1;
      end

      // A stalled MEM/WB slot is replayed later, so only consumed writes count.
      waw_err_next = waw_err_reg | (pw & ~wb_stall & pending_mask[mem_write_reg]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt_reg <= '0;
         reg_write_reg  <= 1'b0;
         write_reg_reg  <= '0;
         write_data_reg <= '0;
         waw_err_reg    <= 1'b0;
      end else begin
         starve_cnt_reg <= starve_cnt_next;
         reg_write_reg  <= reg_write_next;
         write_reg_reg  <= write_reg_next;
         write_data_reg <= write_data_next;
         waw_err_reg    <= waw_err_next;
      end
   end

   assign reg_write  = reg_write_reg;
   assign write_reg  = write_reg_reg;
   assign write_data = write_data_reg;
   assign waw_err    = waw_err_reg;

endmodule

// File: tb/tb_wb_writer.sv
// Directed bench for wb_writer: each task drives one scenario and checks
// the write port, handshake and hazard outputs one cycle at a time.
module tb_wb_writer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_valid, mem_reg_write, mem_mem_to_reg;
   logic [4:0]  mem_write_reg;
   logic [31:0] mem_alu_result, mem_read_data;
   logic        wb_stall;
   logic        md_valid, md_ready;
   logic [4:0]  md_write_reg;
   logic [31:0] md_result;
   logic        reg_write;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic [31:0] pending_mask;
   logic        waw_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   wb_writer #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mem_valid      (mem_valid),
      .mem_reg_write  (mem_reg_write),
      .mem_mem_to_reg (mem_mem_to_reg),
      .mem_write_reg  (mem_write_reg),
      .mem_alu_result (mem_alu_result),
      .mem_read_data  (mem_read_data),
      .wb_stall       (wb_stall),
      .md_valid       (md_valid),
      .md_ready       (md_ready),
      .md_write_reg   (md_write_reg),
      .md_result      (md_result),
      .reg_write      (reg_write),
      .write_reg      (write_reg),
      .write_data     (write_data),
      .pending_mask   (pending_mask),
      .waw_err        (waw_err)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      mem_valid      = 1'b0;
      mem_reg_write  = 1'b0;
      mem_mem_to_reg = 1'b0;
      mem_write_reg  = 5'd0;
      mem_alu_result = 32'h0;
      mem_read_data  = 32'h0;
      md_valid       = 1'b0;
      md_write_reg   = 5'd0;
      md_result      = 32'h0;
   endtask

   task automatic drive_pipe(input logic [4:0] r, input logic [31:0] d);
      mem_valid      = 1'b1;
      mem_reg_write  = 1'b1;
      mem_mem_to_reg = 1'b0;
      mem_write_reg  = r;
      mem_alu_result = d;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      $display("txn reset: we=%0b rd=%0d wd=%h rdy=%0b pm=%h", reg_write, write_reg, write_data, md_ready, pending_mask);
      checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b want 0", reg_write); end
      checks++; if (write_reg !== 5'd0) begin errors++; $display("FAIL reset_wr: got %0d want 0", write_reg); end
      checks++; if (write_data !== 32'h0) begin errors++; $display("FAIL reset_wd: got %h want 0", write_data); end
      checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %0b want 1", md_ready); end
      checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL reset_pm: got %h want 0", pending_mask); end
      checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", wb_stall); end
      checks++; if (waw_err !== 1'b0) begin errors++; $display("FAIL reset_waw: got %0b want 0", waw_err); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_pipeline;
      drive_pipe(5'd5, 32'h1234);
      mem_read_data = 32'hBEEF;
      step();
      $display("txn pipe alu: we=%0b rd=%0d wd=%h", reg_write, write_reg, write_data);
      checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL pipe_alu_we: got %0b want 1", reg_write); end
      checks++; if (write_reg !== 5'd5) begin errors++; $display("FAIL pipe_alu_wr: got %0d want 5", write_reg); end
      checks++; if (write_data !== 32'h1234) begin errors++; $display("FAIL pipe_alu_wd: got %h want 1234", write_data); end
      mem_mem_to_reg = 1'b1;
      mem_read_data  = 32'hDEAD;
      step();
      $display("txn pipe load: we=%0b rd=%0d wd=%h", reg_write, write_reg, write_data);
      checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL pipe_ld_we: got %0b want 1", reg_write); end
      checks++; if (write_data !== 32'hDEAD) begin errors++; $display("FAIL pipe_ld_wd: got %h want dead", write_data); end
      // Valid slot that does not write a register: port idles, address/data hold.
      mem_reg_write = 1'b0;
      mem_write_reg = 5'd6;
      step();
      $display("txn pipe nowrite: we=%0b rd=%0d wd=%h", reg_write, write_reg, write_data);
      checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL pipe_nw_we: got %0b want 0", reg_write); end
      checks++; if (write_reg !== 5'd5) begin errors++; $display("FAIL pipe_hold_wr: got %0d want 5", write_reg); end
      checks++; if (write_data !== 32'hDEAD) begin errors++; $display("FAIL pipe_hold_wd: got %h want dead", write_data); end
      idle_inputs();
   endtask

   task automatic test_zero;
      drive_pipe(5'd0, 32'h5555);
      md_valid     = 1'b1;
      md_write_reg = 5'd0;
      md_result    = 32'h6666;
      #1;
      checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL zero_rdy: got %0b want 1", md_ready); end
      step();
      idle_inputs();
      $display("txn zero: we=%0b pm=%h", reg_write, pending_mask);
      checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL zero_we: got %0b want 0", reg_write); end
      checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL zero_pm: got %h want 0", pending_mask); end
      step();
      checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL zero_late_we: got %0b want 0", reg_write); end
   endtask

   task automatic test_md;
      md_valid     = 1'b1;
      md_write_reg = 5'd9;
      md_result    = 32'hCAFE;
      step();
      md_valid = 1'b0;
      $display("txn md accept: pm=%h we=%0b", pending_mask, reg_write);
      checks++; if (pending_mask !== 32'h0000_0200) begin errors++; $display("FAIL md_pm_set: got %h want 00000200", pending_mask); end
      checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL md_early_we: got %0b want 0", reg_write); end
      step();
      $display("txn md write: we=%0b rd=%0d wd=%h pm=%h", reg_write, write_reg, write_data, pending_mask);
      checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL md_we: got %0b want 1", reg_write); end
      checks++; if (write_reg !== 5'd9) begin errors++; $display("FAIL md_wr: got %0d want 9", write_reg); end
      checks++; if (write_data !== 32'hCAFE) begin errors++; $display("FAIL md_wd: got %h want cafe", write_data); end
      checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL md_pm_clr: got %h want 0", pending_mask); end
      step();
      checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL md_after_we: got %0b want 0", reg_write); end
   endtask

   task automatic test_starve;
      logic [31:0] exp_d;
      logic        exp_stall;
      md_valid     = 1'b1;
      md_write_reg = 5'd7;
      md_result    = 32'h7777;
      drive_pipe(5'd2, 32'h2000);
      step();
      md_valid = 1'b0;
      checks++; if (write_data !== 32'h2000 || write_reg !== 5'd2) begin errors++; $display("FAIL starve_first: got r%0d=%h want r2=2000", write_reg, write_data); end
      checks++; if (pending_mask !== 32'h0000_0080) begin errors++; $display("FAIL starve_pm: got %h want 00000080", pending_mask); end
      for (int i = 1; i <= 3; i++) begin
         mem_alu_result = 32'h2000 + 32'(i);
         exp_d          = 32'h2000 + 32'(i);
         exp_stall      = (i == 3);
         step();
         $display("txn starve cycle %0d: rd=%0d wd=%h stall=%0b", i, write_reg, write_data, wb_stall);
         checks++; if (write_data !== exp_d) begin errors++; $display("FAIL starve_wd%0d: got %h want %h", i, write_data, exp_d); end
         checks++; if (wb_stall !== exp_stall) begin errors++; $display("FAIL starve_stall%0d: got %0b want %0b", i, wb_stall, exp_stall); end
      end
      // This slot is stalled; upstream keeps presenting it.
      drive_pipe(5'd8, 32'h8888);
      step();
      $display("txn starve pop: we=%0b rd=%0d wd=%h", reg_write, write_reg, write_data);
      checks++; if (reg_write !== 1'b1 || write_reg !== 5'd7) begin errors++; $display("FAIL starve_pop_wr: got we=%0b r%0d want we=1 r7", reg_write, write_reg); end
      checks++; if (write_data !== 32'h7777) begin errors++; $display("FAIL starve_pop_wd: got %h want 7777", write_data); end
      checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL starve_unstall: got %0b want 0", wb_stall); end
      step();
      idle_inputs();
      $display("txn starve held: rd=%0d wd=%h", write_reg, write_data);
      checks++; if (write_reg !== 5'd8 || write_data !== 32'h8888) begin errors++; $display("FAIL starve_held: got r%0d=%h want r8=8888", write_reg, write_data); end
      step();
   endtask

   task automatic test_full_waw;
      logic [4:0]  md_r [4];
      logic [31:0] md_d [4];
      logic [4:0]  pp_r [4];
      logic        exp_waw;
      md_r = '{5'd3, 5'd4, 5'd3, 5'd6};
      md_d = '{32'hA3, 32'hA4, 32'hB3, 32'hA6};
      pp_r = '{5'd1, 5'd3, 5'd1, 5'd1};
      for (int i = 0; i < 4; i++) begin
         md_valid     = 1'b1;
         md_write_reg = md_r[i];
         md_result    = md_d[i];
         drive_pipe(pp_r[i], 32'h100 + 32'(i));
         exp_waw = (i >= 1);
         step();
         $display("txn fill %0d: rd=%0d wd=%h waw=%0b pm=%h", i, write_reg, write_data, waw_err, pending_mask);
         checks++; if (write_reg !== pp_r[i]) begin errors++; $display("FAIL fill_wr%0d: got %0d want %0d", i, write_reg, pp_r[i]); end
         checks++; if (waw_err !== exp_waw) begin errors++; $display("FAIL fill_waw%0d: got %0b want %0b", i, waw_err, exp_waw); end
      end
      checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL full_rdy: got %0b want 0", md_ready); end
      checks++; if (wb_stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %0b want 1", wb_stall); end
      checks++; if (pending_mask !== 32'h0000_0058) begin errors++; $display("FAIL full_pm: got %h want 00000058", pending_mask); end
      // Offer reg 10 while full: it must not be taken even though a pop happens.
      md_write_reg = 5'd10;
      md_result    = 32'hAAAA;
      drive_pipe(5'd1, 32'h200);
      step();
      md_valid = 1'b0;
      $display("txn full pop: rd=%0d wd=%h pm=%h rdy=%0b", write_reg, write_data, pending_mask, md_ready);
      checks++; if (write_reg !== 5'd3 || write_data !== 32'hA3) begin errors++; $display("FAIL full_pop: got r%0d=%h want r3=a3", write_reg, write_data); end
      checks++; if (pending_mask !== 32'h0000_0058) begin errors++; $display("FAIL dup_pm: got %h want 00000058", pending_mask); end
      checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL full_rdy_back: got %0b want 1", md_ready); end
      step();
      idle_inputs();
      checks++; if (write_reg !== 5'd1 || write_data !== 32'h200) begin errors++; $display("FAIL full_held: got r%0d=%h want r1=200", write_reg, write_data); end
      step();
      checks++; if (write_reg !== 5'd4 || pending_mask !== 32'h0000_0048) begin errors++; $display("FAIL drain1: got r%0d pm=%h want r4 pm=00000048", write_reg, pending_mask); end
      step();
      checks++; if (write_reg !== 5'd3 || write_data !== 32'hB3 || pending_mask !== 32'h0000_0040) begin errors++; $display("FAIL drain2: got r%0d=%h pm=%h want r3=b3 pm=00000040", write_reg, write_data, pending_mask); end
      step();
      checks++; if (write_reg !== 5'd6 || pending_mask !== 32'h0) begin errors++; $display("FAIL drain3: got r%0d pm=%h want r6 pm=0", write_reg, pending_mask); end
      step();
      $display("txn drained: we=%0b waw=%0b", reg_write, waw_err);
      checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL drain_done_we: got %0b want 0", reg_write); end
      checks++; if (waw_err !== 1'b1) begin errors++; $display("FAIL waw_sticky: got %0b want 1", waw_err); end
   endtask

   task automatic test_reset_mid;
      md_valid     = 1'b1;
      md_write_reg = 5'd11;
      md_result    = 32'hB0B;
      drive_pipe(5'd1, 32'h11);
      step();
      md_write_reg = 5'd12;
      md_result    = 32'hC0C;
      step();
      checks++; if (pending_mask !== 32'h0000_1800) begin errors++; $display("FAIL mid_pm_pre: got %h want 00001800", pending_mask); end
      #2;
      rst_n = 1'b0;
      #1;
      $display("txn async reset: we=%0b rdy=%0b pm=%h waw=%0b", reg_write, md_ready, pending_mask, waw_err);
      checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL mid_we: got %0b want 0", reg_write); end
      checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL mid_rdy: got %0b want 1", md_ready); end
      checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL mid_pm: got %h want 0", pending_mask); end
      checks++; if (waw_err !== 1'b0) begin errors++; $display("FAIL mid_waw: got %0b want 0", waw_err); end
      checks++; if (write_reg !== 5'd0 || write_data !== 32'h0) begin errors++; $display("FAIL mid_port: got r%0d=%h want r0=0", write_reg, write_data); end
      idle_inputs();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (reg_write !== 1'b0 || pending_mask !== 32'h0) begin errors++; $display("FAIL post_reset%0d: got we=%0b pm=%h want we=0 pm=0", i, reg_write, pending_mask); end
      end
   endtask

   initial begin
      test_reset();
      test_pipeline();
      test_zero();
      test_md();
      test_starve();
      test_full_waw();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
